register_file: RTL and testbench

Integer register file for the DLX datapath: sink of the write-back stage and source of operands for decode. One synchronous write port takes the value selected by write-back. Two registered read ports feed decode, with write-to-read bypass in the same cycle. A pending-write scoreboard lets decode detect RAW hazards against instructions still in flight. Register R0 reads as zero and is never written or marked pending.

---
 rtl/register_file.sv | 85 ++++++++
 tb/tb_register_file.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// DLX integer register file: one write-back port, two registered read ports with
// same-cycle write bypass, and a pending-write scoreboard for RAW hazard detection.
module register_file #(
    parameter int unsigned N      = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N-1:0]      wr_data,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [N-1:0]      rd1_data,
    output logic              rd1_pending,
    input  logic              rd2_en,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [N-1:0]      rd2_data,
    output logic              rd2_pending,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic              any_pending
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [N-1:0]     regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_next;
    logic [N-1:0]     rd1_next;
    logic [N-1:0]     rd2_next;

    // Post-edge scoreboard: a write clears, a mark to the same register wins.
    always_comb begin
        pend_next = pend;
        if (wr_en && (wr_addr != '0))
            pend_next[wr_addr] = 1'b0;
        if (mark_en && (mark_addr != '0))
            pend_next[mark_addr] = 1'b1;
        pend_next[0] = 1'b0;
    end

    always_comb begin
        rd1_next = regs[rd1_addr];
        if (wr_en && (wr_addr == rd1_addr))
            rd1_next = wr_data;
        if (rd1_addr == '0)
            rd1_next = '0;
    end

    always_comb begin
        rd2_next = regs[rd2_addr];
        if (wr_en && (wr_addr == rd2_addr))
            rd2_next = wr_data;
        if (rd2_addr == '0)
            rd2_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            pend        <= '0;
            rd1_data    <= '0;
            rd1_pending <= 1'b0;
            rd2_data    <= '0;
            rd2_pending <= 1'b0;
            any_pending <= 1'b0;
        end else begin
            if (wr_en && (wr_addr != '0))
                regs[wr_addr] <= wr_data;
            pend <= pend_next;
            if (rd1_en) begin
                rd1_data    <= rd1_next;
                rd1_pending <= pend_next[rd1_addr];
            end
            if (rd2_en) begin
                rd2_data    <= rd2_next;
                rd2_pending <= pend_next[rd2_addr];
            end
            any_pending <= |pend_next;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by random
// traffic, all compared against an array-based model of post-edge contents.
module tb_register_file;

    localparam int N     = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic          rd1_en;
    logic [AW-1:0] rd1_addr;
    logic [N-1:0]  rd1_data;
    logic          rd1_pending;
    logic          rd2_en;
    logic [AW-1:0] rd2_addr;
    logic [N-1:0]  rd2_data;
    logic          rd2_pending;
    logic          mark_en;
    logic [AW-1:0] mark_addr;
    logic          any_pending;

    always #5 clk = ~clk;

    register_file #(.N(N), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd1_en      (rd1_en),
        .rd1_addr    (rd1_addr),
        .rd1_data    (rd1_data),
        .rd1_pending (rd1_pending),
        .rd2_en      (rd2_en),
        .rd2_addr    (rd2_addr),
        .rd2_data    (rd2_data),
        .rd2_pending (rd2_pending),
        .mark_en     (mark_en),
        .mark_addr   (mark_addr),
        .any_pending (any_pending)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: what the register file holds after each edge.
    logic [N-1:0] m_regs [DEPTH];
    logic         m_pend [DEPTH];
    logic [N-1:0] m_d1, m_d2;
    logic         m_p1, m_p2, m_any;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd1_en = 1'b0; rd1_addr = '0; rd2_en = 1'b0; rd2_addr = '0;
        mark_en = 1'b0; mark_addr = '0;
    endtask

    // A read observes the register file as it stands after the edge, which
    // covers bypass and same-cycle mark/clear without special cases.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
            m_d1 = '0; m_d2 = '0; m_p1 = 1'b0; m_p2 = 1'b0; m_any = 1'b0;
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (mark_en && mark_addr != 0)
                m_pend[mark_addr] = 1'b1;
            if (rd1_en) begin
                m_d1 = m_regs[rd1_addr];
                m_p1 = m_pend[rd1_addr];
            end
            if (rd2_en) begin
                m_d2 = m_regs[rd2_addr];
                m_p2 = m_pend[rd2_addr];
            end
            m_any = 1'b0;
            for (int i = 0; i < DEPTH; i++)
                m_any = m_any | m_pend[i];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("rd1_data", rd1_data, m_d1);
        check("rd1_pending", 32'(rd1_pending), 32'(m_p1));
        check("rd2_data", rd2_data, m_d2);
        check("rd2_pending", 32'(rd2_pending), 32'(m_p2));
        check("any_pending", 32'(any_pending), 32'(m_any));
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0)
            return AW'($urandom_range(0, DEPTH - 1));
        return AW'($urandom_range(0, 3));
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_d1 = '0; m_d2 = '0; m_p1 = 1'b0; m_p2 = 1'b0; m_any = 1'b0;

        // Reset with a write attempted during it
        set_idle();
        rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        cycle();
        cycle();
        set_idle();
        rd1_en = 1'b1; rd1_addr = 5'd3;
        cycle();
        check("reset_r3_data", rd1_data, 32'h0);
        check("reset_r3_pend", 32'(rd1_pending), 32'h0);
        check("reset_any", 32'(any_pending), 32'h0);

        // Basic write then dual-port read, then hold
        set_idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
        cycle();
        set_idle();
        rd1_en = 1'b1; rd1_addr = 5'd5; rd2_en = 1'b1; rd2_addr = 5'd5;
        cycle();
        check("basic_rd1", rd1_data, 32'h12345678);
        check("basic_rd2", rd2_data, 32'h12345678);
        set_idle();
        rd1_addr = 5'd3; rd2_addr = 5'd0;
        cycle();
        check("hold_rd1", rd1_data, 32'h12345678);
        check("hold_rd2", rd2_data, 32'h12345678);

        // R0 is hardwired
        set_idle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        mark_en = 1'b1; mark_addr = 5'd0;
        cycle();
        set_idle();
        rd1_en = 1'b1; rd1_addr = 5'd0; rd2_en = 1'b1; rd2_addr = 5'd0;
        cycle();
        check("r0_data", rd1_data, 32'h0);
        check("r0_pend", 32'(rd1_pending), 32'h0);
        check("r0_any", 32'(any_pending), 32'h0);

        // Same-cycle bypass
        set_idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        rd2_en = 1'b1; rd2_addr = 5'd7; rd1_en = 1'b1; rd1_addr = 5'd8;
        cycle();
        check("bypass_rd2", rd2_data, 32'hA5A5A5A5);
        check("bypass_rd1_r8", rd1_data, 32'h0);

        // Scoreboard mark / clear / mark-wins
        set_idle();
        mark_en = 1'b1; mark_addr = 5'd9;
        cycle();
        set_idle();
        rd1_en = 1'b1; rd1_addr = 5'd9;
        cycle();
        check("mark_pend", 32'(rd1_pending), 32'h1);
        check("mark_any", 32'(any_pending), 32'h1);
        set_idle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        cycle();
        set_idle();
        rd1_en = 1'b1; rd1_addr = 5'd9;
        cycle();
        check("clear_data", rd1_data, 32'h55);
        check("clear_pend", 32'(rd1_pending), 32'h0);
        check("clear_any", 32'(any_pending), 32'h0);
        set_idle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h66;
        mark_en = 1'b1; mark_addr = 5'd9;
        rd1_en = 1'b1; rd1_addr = 5'd9;
        cycle();
        check("markwin_data", rd1_data, 32'h66);
        check("markwin_pend", 32'(rd1_pending), 32'h1);

        // Reset discards in-flight marks
        set_idle();
        mark_en = 1'b1; mark_addr = 5'd1;
        cycle();
        mark_addr = 5'd2;
        cycle();
        mark_addr = 5'd31;
        cycle();
        set_idle();
        rst = 1'b1;
        cycle();
        check("midrst_any", 32'(any_pending), 32'h0);
        set_idle();
        rd1_en = 1'b1; rd1_addr = 5'd31; rd2_en = 1'b1; rd2_addr = 5'd9;
        cycle();
        check("midrst_r31_data", rd1_data, 32'h0);
        check("midrst_r31_pend", 32'(rd1_pending), 32'h0);
        check("midrst_r9_data", rd2_data, 32'h0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = rand_addr();
            wr_data   = $urandom();
            rd1_en    = ($urandom_range(0, 3) != 0);
            rd1_addr  = rand_addr();
            rd2_en    = ($urandom_range(0, 3) != 0);
            rd2_addr  = rand_addr();
            mark_en   = 1'($urandom_range(0, 1));
            mark_addr = rand_addr();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
